// File: rtl/judge_pkg.sv
// judge_pkg -- shared types and constants for the note_judge rhythm-game judge.
// Contents:
//   state_t    : judge FSM states (IDLE, ARMED, JUDGE, DONE)
//   result_t   : verdict codes on the result port (NONE/PERFECT/GOOD/MISS)
//   *_PTS      : score increments for PERFECT and GOOD hits
//   sat_add16  : 16-bit saturating add used for the score
package judge_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_JUDGE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PERFECT = 2'd1,
        RES_GOOD    = 2'd2,
        RES_MISS    = 2'd3
    } result_t;

    localparam logic [15:0] PERFECT_PTS = 16'd2;
    localparam logic [15:0] GOOD_PTS    = 16'd1;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/note_judge_if.sv
// note_judge_if -- groups the game-control inputs and judge outputs of note_judge.
// Signals:
//   gameSTART    : level, high enables judging
//   beat         : beat square wave, each rising edge opens a slot
//   expected     : recorded key code for the current beat (0 = rest)
//   arbiter      : player key code (0 = no key)
//   result       : verdict code, qualified by result_valid
//   result_valid : one-cycle pulse
//   score, combo, max_combo, beat_idx, done : game status
// Modports: master drives the inputs (game/player side), slave is the judge.
interface note_judge_if;

    logic        gameSTART;
    logic        beat;
    logic [5:0]  expected;
    logic [5:0]  arbiter;
    logic [1:0]  result;
    logic        result_valid;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [8:0]  beat_idx;
    logic        done;

    modport master (
        output gameSTART, beat, expected, arbiter,
        input  result, result_valid, score, combo, max_combo, beat_idx, done
    );

    modport slave (
        input  gameSTART, beat, expected, arbiter,
        output result, result_valid, score, combo, max_combo, beat_idx, done
    );

endinterface

// File: rtl/rise_detect.sv
// rise_detect -- single-cycle rising-edge detector for a synchronous level.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   sig        : monitored level
//   rise       : high in the cycle where sig is 1 and was 0 on the previous edge
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/note_judge.sv
// note_judge -- judges player key presses against a recorded beat track.
// Each beat rising edge opens a slot and latches the expected key code.
// The first press in a slot is graded by how many cycles have elapsed
// since the slot opened (PERFECT / GOOD / MISS); a slot with a note and no
// press is reported as MISS when the next slot opens.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   bus        : note_judge_if.slave (game inputs, verdict and status outputs)
// Parameters:
//   PERFECT_WIN, GOOD_WIN : elapsed-cycle windows for PERFECT and GOOD
//   N_BEATS               : slots per song
module note_judge
    import judge_pkg::*;
#(
    parameter logic [23:0] PERFECT_WIN = 24'd2_500_000,
    parameter logic [23:0] GOOD_WIN    = 24'd7_500_000,
    parameter logic [9:0]  N_BEATS     = 10'd512
) (
    input  logic         clk,
    input  logic         reset,
    note_judge_if.slave  bus
);

    state_t      state, state_next;
    logic        start_rise, beat_rise;
    logic [5:0]  arb_prev;
    logic [23:0] elapsed;
    logic [5:0]  slot_code;
    logic        judged;
    logic        carry_valid;
    logic [5:0]  carry_code;

    result_t     result_q;
    logic        result_valid_q;
    logic [15:0] score_q;
    logic [7:0]  combo_q, max_combo_q;
    logic [8:0]  beat_idx_q;
    logic        done_q;

    logic        press, in_play, slot_open, last_slot, miss_on_edge, judge_now;
    logic        issue, code_match;
    result_t     verdict;
    logic [5:0]  judge_code;
    logic [23:0] judge_elapsed;
    logic [15:0] score_next;
    logic [7:0]  combo_next, max_next;

    rise_detect u_start_rise (.clk(clk), .reset(reset), .sig(bus.gameSTART), .rise(start_rise));
    rise_detect u_beat_rise  (.clk(clk), .reset(reset), .sig(bus.beat),      .rise(beat_rise));

    // A press is any change of the key code to a nonzero value.
    assign press        = (bus.arbiter != 6'd0) && (bus.arbiter != arb_prev);
    assign in_play      = (state == S_JUDGE) && bus.gameSTART;
    assign slot_open    = (slot_code != 6'd0) && !judged;
    assign last_slot    = ({1'b0, beat_idx_q} == (N_BEATS - 10'd1));
    assign miss_on_edge = in_play && beat_rise && slot_open;
    // A press coinciding with a beat edge is parked in carry_* and graded
    // one cycle later against the new slot, so on an edge we never judge.
    assign judge_now    = in_play && !beat_rise && (carry_valid || press) && slot_open;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_rise) state_next = S_ARMED;
            S_ARMED: begin
                if (!bus.gameSTART)  state_next = S_IDLE;
                else if (beat_rise)  state_next = S_JUDGE;
            end
            S_JUDGE: begin
                if (!bus.gameSTART)              state_next = S_IDLE;
                else if (beat_rise && last_slot) state_next = S_DONE;
            end
            S_DONE:  if (!bus.gameSTART) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Grade the press being judged this cycle (a parked one wins and counts as elapsed 0).
    always_comb begin
        verdict       = RES_NONE;
        issue         = 1'b0;
        judge_code    = carry_valid ? carry_code : bus.arbiter;
        judge_elapsed = carry_valid ? 24'd0 : elapsed;
        code_match    = (judge_code == slot_code);
        if (miss_on_edge) begin
            issue   = 1'b1;
            verdict = RES_MISS;
        end else if (judge_now) begin
            issue = 1'b1;
            if (code_match && (judge_elapsed < PERFECT_WIN))   verdict = RES_PERFECT;
            else if (code_match && (judge_elapsed < GOOD_WIN)) verdict = RES_GOOD;
            else                                               verdict = RES_MISS;
        end
    end

    always_comb begin
        score_next = score_q;
        combo_next = combo_q;
        case (verdict)
            RES_PERFECT: begin
                score_next = sat_add16(score_q, PERFECT_PTS);
                combo_next = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
            end
            RES_GOOD: begin
                score_next = sat_add16(score_q, GOOD_PTS);
                combo_next = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
            end
            RES_MISS: combo_next = 8'd0;
            default:  ;
        endcase
        max_next = (combo_next > max_combo_q) ? combo_next : max_combo_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_prev       <= 6'd0;
            elapsed        <= 24'd0;
            slot_code      <= 6'd0;
            judged         <= 1'b0;
            carry_valid    <= 1'b0;
            carry_code     <= 6'd0;
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
            score_q        <= 16'd0;
            combo_q        <= 8'd0;
            max_combo_q    <= 8'd0;
            beat_idx_q     <= 9'd0;
            done_q         <= 1'b0;
        end else begin
            arb_prev       <= bus.arbiter;
            result_valid_q <= issue;
            carry_valid    <= 1'b0;
            if (issue) begin
                result_q    <= verdict;
                score_q     <= score_next;
                combo_q     <= combo_next;
                max_combo_q <= max_next;
            end
            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        score_q     <= 16'd0;
                        combo_q     <= 8'd0;
                        max_combo_q <= 8'd0;
                        beat_idx_q  <= 9'd0;
                        done_q      <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (bus.gameSTART && beat_rise) begin
                        elapsed     <= 24'd0;
                        slot_code   <= bus.expected;
                        judged      <= 1'b0;
                        carry_valid <= press;
                        carry_code  <= bus.arbiter;
                    end
                end
                S_JUDGE: begin
                    if (bus.gameSTART) begin
                        if (beat_rise) begin
                            if (last_slot) begin
                                done_q <= 1'b1;
                            end else begin
                                beat_idx_q  <= beat_idx_q + 9'd1;
                                elapsed     <= 24'd0;
                                slot_code   <= bus.expected;
                                judged      <= 1'b0;
                                carry_valid <= press;
                                carry_code  <= bus.arbiter;
                            end
                        end else begin
                            if (elapsed != 24'hFFFFFF) elapsed <= elapsed + 24'd1;
                            if (judge_now) judged <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.score        = score_q;
    assign bus.combo        = combo_q;
    assign bus.max_combo    = max_combo_q;
    assign bus.beat_idx     = beat_idx_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge -- directed self-checking bench for note_judge with
// PERFECT_WIN=4, GOOD_WIN=10, N_BEATS=3. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_note_judge;
    import judge_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    note_judge_if bus ();

    note_judge #(
        .PERFECT_WIN(24'd4),
        .GOOD_WIN   (24'd10),
        .N_BEATS    (10'd3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // gameSTART low then high: lands in ARMED with status cleared
    task automatic start_game();
        bus.gameSTART = 1'b0;
        tick();
        bus.gameSTART = 1'b1;
        tick();
    endtask

    // Beat rising edge with the given recorded code; returns with elapsed = 0
    task automatic beat_edge(input logic [5:0] code);
        bus.expected = code;
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
    endtask

    // Press a key when elapsed == at; returns on the cycle the verdict is visible
    task automatic press(input logic [5:0] code, input int at);
        repeat (at) tick();
        bus.arbiter = code;
        tick();
        bus.arbiter = 6'd0;
    endtask

    task automatic test_reset();
        tick();
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0d want 0", bus.result_valid); end
        vectors++; if (bus.score !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_score: got %0h want 0", bus.score); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0d want 0", bus.done); end
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want 0", dut.state); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_perfect();
        start_game();
        beat_edge(6'd5);
        press(6'd5, 2);
        vectors++; if (bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL perfect_valid: got %0d want 1", bus.result_valid); end
        vectors++; if (bus.result !== 2'd1) begin miscompares++; $display("[TB] FAIL perfect_result: got %0d want 1", bus.result); end
        vectors++; if (bus.score !== 16'd2) begin miscompares++; $display("[TB] FAIL perfect_score: got %0d want 2", bus.score); end
        vectors++; if (bus.combo !== 8'd1) begin miscompares++; $display("[TB] FAIL perfect_combo: got %0d want 1", bus.combo); end
        tick();
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL perfect_pulse_len: got %0d want 0", bus.result_valid); end
        vectors++; if (bus.result !== 2'd1) begin miscompares++; $display("[TB] FAIL perfect_hold: got %0d want 1", bus.result); end
    endtask

    task automatic test_good_and_miss();
        start_game();
        beat_edge(6'd5);
        press(6'd5, 7);
        vectors++; if (bus.result !== 2'd2 || bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL good_result: got %0d/%0d want 2/1", bus.result, bus.result_valid); end
        vectors++; if (bus.score !== 16'd1) begin miscompares++; $display("[TB] FAIL good_score: got %0d want 1", bus.score); end
        beat_edge(6'd5);
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL judged_slot_no_miss: got %0d want 0", bus.result_valid); end
        press(6'd3, 1);
        vectors++; if (bus.result !== 2'd3 || bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wrong_key_miss: got %0d/%0d want 3/1", bus.result, bus.result_valid); end
        vectors++; if (bus.combo !== 8'd0) begin miscompares++; $display("[TB] FAIL wrong_key_combo: got %0d want 0", bus.combo); end
        vectors++; if (bus.max_combo !== 8'd1 || bus.score !== 16'd1) begin miscompares++; $display("[TB] FAIL wrong_key_max_score: got %0d/%0d want 1/1", bus.max_combo, bus.score); end
        vectors++; if (bus.beat_idx !== 9'd1) begin miscompares++; $display("[TB] FAIL wrong_key_idx: got %0d want 1", bus.beat_idx); end
        press(6'd5, 1);
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL second_press_ignored: got %0d want 0", bus.result_valid); end
        beat_edge(6'd5);
        press(6'd5, 10);
        vectors++; if (bus.result !== 2'd3 || bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL late_miss: got %0d/%0d want 3/1", bus.result, bus.result_valid); end
    endtask

    task automatic test_no_press_and_rest();
        start_game();
        beat_edge(6'd5);
        repeat (3) tick();
        beat_edge(6'd0);
        vectors++; if (bus.result !== 2'd3 || bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL unpressed_miss: got %0d/%0d want 3/1", bus.result, bus.result_valid); end
        vectors++; if (bus.beat_idx !== 9'd1) begin miscompares++; $display("[TB] FAIL unpressed_idx: got %0d want 1", bus.beat_idx); end
        press(6'd5, 1);
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rest_press_ignored: got %0d want 0", bus.result_valid); end
        beat_edge(6'd5);
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rest_no_miss: got %0d want 0", bus.result_valid); end
        press(6'd5, 0);
        vectors++; if (bus.result !== 2'd1 || bus.score !== 16'd2) begin miscompares++; $display("[TB] FAIL after_rest_perfect: got %0d/%0d want 1/2", bus.result, bus.score); end
    endtask

    task automatic test_same_cycle();
        start_game();
        beat_edge(6'd5);
        repeat (2) tick();
        bus.expected = 6'd5;
        bus.beat = 1'b1;
        bus.arbiter = 6'd5;
        tick();
        bus.beat = 1'b0;
        bus.arbiter = 6'd0;
        vectors++; if (bus.result !== 2'd3 || bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL same_cycle_miss: got %0d/%0d want 3/1", bus.result, bus.result_valid); end
        vectors++; if (bus.beat_idx !== 9'd1) begin miscompares++; $display("[TB] FAIL same_cycle_idx: got %0d want 1", bus.beat_idx); end
        tick();
        vectors++; if (bus.result !== 2'd1 || bus.result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL same_cycle_perfect: got %0d/%0d want 1/1", bus.result, bus.result_valid); end
        vectors++; if (bus.score !== 16'd2 || bus.combo !== 8'd1) begin miscompares++; $display("[TB] FAIL same_cycle_score: got %0d/%0d want 2/1", bus.score, bus.combo); end
    endtask

    task automatic test_stop();
        beat_edge(6'd5);
        bus.gameSTART = 1'b0;
        tick();
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("[TB] FAIL stop_state: got %0d want 0", dut.state); end
        tick();
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_no_miss: got %0d want 0", bus.result_valid); end
        vectors++; if (bus.score !== 16'd2 || bus.combo !== 8'd1 || bus.max_combo !== 8'd1) begin miscompares++; $display("[TB] FAIL stop_retain: got %0d/%0d/%0d want 2/1/1", bus.score, bus.combo, bus.max_combo); end
        beat_edge(6'd5);
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_beat: got %0d want 0", bus.result_valid); end
    endtask

    task automatic test_full_song();
        start_game();
        for (int i = 0; i < 3; i++) begin
            beat_edge(6'd5);
            press(6'd5, 1);
        end
        beat_edge(6'd5);
        vectors++; if (bus.score !== 16'd6) begin miscompares++; $display("[TB] FAIL song_score: got %0d want 6", bus.score); end
        vectors++; if (bus.combo !== 8'd3 || bus.max_combo !== 8'd3) begin miscompares++; $display("[TB] FAIL song_combo: got %0d/%0d want 3/3", bus.combo, bus.max_combo); end
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("[TB] FAIL song_done: got %0d want 1", bus.done); end
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL song_close_valid: got %0d want 0", bus.result_valid); end
        beat_edge(6'd5);
        press(6'd5, 1);
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL done_frozen_valid: got %0d want 0", bus.result_valid); end
        vectors++; if (bus.beat_idx !== 9'd2 || bus.score !== 16'd6) begin miscompares++; $display("[TB] FAIL done_frozen: got %0d/%0d want 2/6", bus.beat_idx, bus.score); end
    endtask

    task automatic test_saturate_and_reset();
        start_game();
        beat_edge(6'd5);
        force dut.score_q = 16'hFFFE;
        tick();
        release dut.score_q;
        press(6'd5, 0);
        vectors++; if (bus.result !== 2'd1 || bus.score !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL score_saturate: got %0d/%0h want 1/ffff", bus.result, bus.score); end
        beat_edge(6'd5);
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("[TB] FAIL async_reset_state: got %0d want 0", dut.state); end
        vectors++; if (bus.score !== 16'd0 || bus.combo !== 8'd0 || bus.max_combo !== 8'd0) begin miscompares++; $display("[TB] FAIL async_reset_status: got %0h/%0d/%0d want 0/0/0", bus.score, bus.combo, bus.max_combo); end
        vectors++; if (bus.result !== 2'd0 || bus.result_valid !== 1'b0 || bus.beat_idx !== 9'd0 || bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_result: got %0d/%0d/%0d/%0d want 0/0/0/0", bus.result, bus.result_valid, bus.beat_idx, bus.done); end
        @(negedge clk);
        reset = 1'b0;
        bus.gameSTART = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_slot_discarded: got %0d want 0", bus.result_valid); end
        end
    endtask

    initial begin
        bus.gameSTART = 1'b0;
        bus.beat      = 1'b0;
        bus.expected  = 6'd0;
        bus.arbiter   = 6'd0;
        test_reset();
        test_perfect();
        test_good_and_miss();
        test_no_press_and_rest();
        test_same_cycle();
        test_stop();
        test_full_song();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_judge.md
NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 SHALL have parameter PERFECT_WIN, 24'd2_500_000: cycles after beat edge within which a correct press scores PERFECT.
REQ-002 SHALL have parameter GOOD_WIN, 24'd7_500_000: cycles after beat edge within which a correct press scores GOOD; GOOD_WIN > PERFECT_WIN.
REQ-003 SHALL have parameter N_BEATS, 10'd512: beats per song.
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port gameSTART, input, 1: level; high enables judging.
REQ-007 SHALL have port beat, input, 1: beat square wave; each rising edge opens one beat slot.
REQ-008 SHALL have port expected, input, 6: recorded key code for current beat; 0 = rest.
REQ-009 SHALL have port arbiter, input, 6: player key code; 0 = no key.
REQ-010 SHALL have port result, output, 2: 0 NONE, 1 PERFECT, 2 GOOD, 3 MISS.
REQ-011 SHALL have port result_valid, output, 1: one-cycle pulse qualifying result.
REQ-012 SHALL have port score, output, 16: accumulated score.
REQ-013 SHALL have port combo, output, 8: current streak; max_combo, output, 8: best streak.
REQ-014 SHALL have port beat_idx, output, 9: index of the beat being judged; done, output, 1: song finished.

Function
REQ-015 SHALL run FSM IDLE, ARMED, JUDGE, DONE.
REQ-016 IDLE->ARMED on gameSTART rising edge; entry SHALL clear score, combo, max_combo, beat_idx, done.
REQ-017 ARMED->JUDGE on first beat rising edge; the 24-bit elapsed counter SHALL load 0 and the expected code SHALL be latched.
REQ-018 In JUDGE, elapsed SHALL increment each cycle, saturating at 24'hFFFFFF.
REQ-019 Press event = arbiter transitions from 0 to nonzero, or from one nonzero value to a different nonzero value.
REQ-020 Only the first press per slot SHALL be judged; later presses in that slot SHALL be ignored.
REQ-021 Nonzero latched code with press code equal and elapsed < PERFECT_WIN -> PERFECT, score +2, combo +1.
REQ-022 Equal press code with PERFECT_WIN <= elapsed < GOOD_WIN -> GOOD, score +1, combo +1.
REQ-023 Press code mismatch, or elapsed >= GOOD_WIN -> MISS; combo cleared.
REQ-024 If a slot with a nonzero code ends with no press, MISS SHALL be issued on the next beat rising edge.
REQ-025 Rest slots (code 0) SHALL produce no result; presses during them SHALL be ignored.
REQ-026 result/result_valid SHALL be registered; pulse exactly one cycle after the triggering press or edge; result SHALL hold its last value between pulses.
REQ-027 Press and beat edge in the same cycle: a pending MISS for the old slot SHALL issue this cycle, and the press SHALL be judged in the new slot with elapsed 0 (PERFECT if matched) on the following cycle.
REQ-028 score SHALL saturate at 16'hFFFF; combo SHALL saturate at 255; max_combo = max(max_combo, combo) updated on the same edge as combo.
REQ-029 beat_idx SHALL increment on each beat edge in JUDGE; after slot N_BEATS-1 closes, FSM->DONE, done=1, outputs frozen.
REQ-030 gameSTART low in ARMED/JUDGE/DONE -> IDLE; score, combo, and max_combo retained; no pending MISS issued.
REQ-031 DONE->ARMED only via a new gameSTART rising edge.

Reset
REQ-032 Reset asserted SHALL force IDLE immediately and asynchronously, and SHALL zero result, result_valid, score, combo, max_combo, beat_idx, done, elapsed, and all edge-detect registers.
REQ-033 Reset mid-slot SHALL discard the slot with no result emitted.

Structure
REQ-034 Package judge_pkg SHALL hold the FSM state enum, the result codes (NONE/PERFECT/GOOD/MISS), and score increments (2, 1).
REQ-035 One sub-module rise_detect SHALL be used for beat and gameSTART edge detection.

Verification
REQ-036 PERFECT_WIN=4, GOOD_WIN=10; gameSTART, beat edge, expected=5, arbiter 0->5 at elapsed 2 -> result=1, score=2, combo=1.
REQ-037 Same setup, press code 5 at elapsed 7 -> GOOD, score=1; press code 3 at elapsed 1 -> MISS, combo=0.
REQ-038 expected=5, no press, next beat edge -> MISS pulse one cycle after that edge, beat_idx=1.
REQ-039 N_BEATS=3, three PERFECT slots -> score=6, combo=3, max_combo=3, done=1 after third slot; further beats give no result_valid.
REQ-040 Force score to 16'hFFFE, issue PERFECT -> score=16'hFFFF; assert reset mid-JUDGE -> all outputs 0 and FSM IDLE with no clock edge required.
